seq_det_ctrl: RTL and testbench

- Run controller around a programmable serial pattern detector: up to 16 pattern bits with a programmable length, fed by a shift register.
- Software configures pattern and length, arms a run with start, and the block hunts the gated serial stream for matches.
- Supports single-shot or continuous mode, overlapping or non-overlapping matching, a cycle timeout and abort.
- Sits between the control register interface and the serial input path; reports per-match pulses, run completion and a match count.

---
 rtl/seq_det_ctrl_if.sv | 38 +++
 rtl/seq_det_ctrl.sv | 159 +++++++++++++++
 tb/tb_seq_det_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/seq_det_ctrl_if.sv
// Bundle of control, serial-input and status signals for seq_det_ctrl.
// x_valid has no ready: a bit transfers on any clk edge with x_valid high while a run is active.
interface seq_det_ctrl_if #(
   parameter int MAX_LEN = 16,
   parameter int LEN_W   = $clog2(MAX_LEN + 1),
   parameter int CNT_W   = 8,
   parameter int TO_W    = 16
);
   logic               cfg_we;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LEN_W-1:0]   cfg_len;
   logic [TO_W-1:0]    cfg_timeout;
   logic               cfg_cont;
   logic               cfg_overlap;
   logic               start;
   logic               abort;
   logic               x_valid;
   logic               x_i;
   logic               det_o;
   logic               busy_o;
   logic               done_o;
   logic               timeout_o;
   logic               cfg_err_o;
   logic [CNT_W-1:0]   match_cnt_o;
   logic [1:0]         state_o;

   modport master (
      output cfg_we, cfg_pattern, cfg_len, cfg_timeout, cfg_cont, cfg_overlap,
      output start, abort, x_valid, x_i,
      input  det_o, busy_o, done_o, timeout_o, cfg_err_o, match_cnt_o, state_o
   );

   modport slave (
      input  cfg_we, cfg_pattern, cfg_len, cfg_timeout, cfg_cont, cfg_overlap,
      input  start, abort, x_valid, x_i,
      output det_o, busy_o, done_o, timeout_o, cfg_err_o, match_cnt_o, state_o
   );
endinterface

// File: rtl/seq_det_ctrl.sv
// Run controller around a programmable serial pattern detector (up to MAX_LEN bits),
// with single-shot/continuous runs, overlap control, cycle timeout and abort.
module seq_det_ctrl #(
   parameter int MAX_LEN = 16,
   parameter int LEN_W   = $clog2(MAX_LEN + 1),
   parameter int CNT_W   = 8,
   parameter int TO_W    = 16
) (
   input logic         clk,
   input logic         reset,
   seq_det_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, HUNT = 2'd2, DONE = 2'd3} state_t;

   state_t             state;
   // The oldest window bit is shifted out on every accept, so only MAX_LEN-1 bits are kept.
   logic [MAX_LEN-2:0] hist;
   logic [MAX_LEN-1:0] pat_q;
   logic [LEN_W-1:0]   len_q;
   logic [TO_W-1:0]    to_q;
   logic               cont_q;
   logic               ovl_q;
   logic [LEN_W-1:0]   fill_cnt;
   logic [CNT_W-1:0]   match_cnt;
   logic [TO_W-1:0]    to_cnt;
   logic               to_hit_q;
   logic               det_q;
   logic               busy_q;
   logic               done_q;
   logic               timeout_q;
   logic               cfg_err_q;

   logic               cfg_ok;
   logic [LEN_W-1:0]   start_len;
   logic [MAX_LEN-1:0] shift_nxt;
   logic [LEN_W-1:0]   fill_inc;
   logic               fill_full;
   logic               running;
   logic               accept;
   logic               hit;
   logic               to_expire;

   function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] l);
      logic [MAX_LEN-1:0] m;
      for (int i = 0; i < MAX_LEN; i++) m[i] = (i < int'(l));
      return m;
   endfunction

   assign cfg_ok    = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN));
   // A write in the same cycle as start decides the length the start is judged by.
   assign start_len = (bus.cfg_we && cfg_ok) ? bus.cfg_len : len_q;
   assign shift_nxt = {hist, bus.x_i};
   assign fill_inc  = fill_cnt + 1'b1;
   assign fill_full = (fill_inc >= len_q);
   assign running   = (state == FILL) || (state == HUNT);
   assign accept    = running && bus.x_valid;
   assign hit       = accept && fill_full &&
                      (((shift_nxt ^ pat_q) & len_mask(len_q)) == '0);
   assign to_expire = running && (to_q != '0) && (to_cnt == to_q - 1'b1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         hist      <= '0;
         pat_q     <= '0;
         len_q     <= '0;
         to_q      <= '0;
         cont_q    <= 1'b0;
         ovl_q     <= 1'b0;
         fill_cnt  <= '0;
         match_cnt <= '0;
         to_cnt    <= '0;
         to_hit_q  <= 1'b0;
         det_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         det_q     <= 1'b0;
         cfg_err_q <= 1'b0;
         done_q    <= (state == DONE);
         timeout_q <= (state == DONE) && to_hit_q;
         unique case (state)
            IDLE: begin
               if (bus.cfg_we) begin
                  if (cfg_ok) begin
                     pat_q  <= bus.cfg_pattern;
                     len_q  <= bus.cfg_len;
                     to_q   <= bus.cfg_timeout;
                     cont_q <= bus.cfg_cont;
                     ovl_q  <= bus.cfg_overlap;
                  end else begin
                     cfg_err_q <= 1'b1;
                  end
               end
               if (bus.start) begin
                  if (start_len != '0) begin
                     hist      <= '0;
                     fill_cnt  <= '0;
                     match_cnt <= '0;
                     to_cnt    <= '0;
                     to_hit_q  <= 1'b0;
                     state     <= FILL;
                     busy_q    <= 1'b1;
                  end else begin
                     cfg_err_q <= 1'b1;
                  end
               end
            end
            FILL, HUNT: begin
               if (bus.cfg_we) cfg_err_q <= 1'b1;
               if (bus.abort) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end else begin
                  if (accept) begin
                     hist     <= shift_nxt[MAX_LEN-2:0];
                     fill_cnt <= fill_full ? len_q : fill_inc;
                     if (fill_full) state <= HUNT;
                  end
                  // A match outranks a coincident timeout and restarts the timeout window.
                  if (hit) begin
                     det_q  <= 1'b1;
                     to_cnt <= '0;
                     if (match_cnt != '1) match_cnt <= match_cnt + 1'b1;
                     if (!ovl_q) begin
                        fill_cnt <= '0;
                        state    <= FILL;
                     end
                     if (!cont_q) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                     end
                  end else if (to_expire) begin
                     to_hit_q <= 1'b1;
                     state    <= DONE;
                     busy_q   <= 1'b0;
                  end else begin
                     to_cnt <= to_cnt + 1'b1;
                  end
               end
            end
            default: begin
               if (bus.cfg_we) cfg_err_q <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.det_o       = det_q;
   assign bus.busy_o      = busy_q;
   assign bus.done_o      = done_q;
   assign bus.timeout_o   = timeout_q;
   assign bus.cfg_err_o   = cfg_err_q;
   assign bus.match_cnt_o = match_cnt;
   assign bus.state_o     = state;
endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl: expected output events are queued with their cycle,
// and a negedge monitor pops and compares whenever any output pulse appears.
module tb_seq_det_ctrl;
   logic clk;
   logic reset;
   int   cyc;
   int   checks;
   int   errors;

   logic [11:0] exp_q[$];
   int          exp_cyc_q[$];

   seq_det_ctrl_if bus ();

   seq_det_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // event vector: {det, done, timeout, cfg_err, match_cnt[7:0]}
   task automatic push(input int at, input logic d, input logic dn, input logic t,
                       input logic e, input logic [7:0] mc);
      exp_q.push_back({d, dn, t, e, mc});
      exp_cyc_q.push_back(at);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      logic [11:0] act;
      logic [11:0] e;
      int          c;
      act = {bus.det_o, bus.done_o, bus.timeout_o, bus.cfg_err_o, bus.match_cnt_o};
      if (!reset && (bus.det_o || bus.done_o || bus.timeout_o || bus.cfg_err_o)) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got %03h at cyc %0d, none expected", act, cyc);
         end else begin
            e = exp_q.pop_front();
            c = exp_cyc_q.pop_front();
            if (act !== e || cyc != c) begin
               errors++;
               $display("FAIL event: got %03h at cyc %0d expected %03h at cyc %0d", act, cyc, e, c);
            end
         end
      end
   end

   // driver tasks
   task automatic drive(input logic xv, input logic xi, input logic st, input logic ab);
      bus.x_valid = xv;
      bus.x_i     = xi;
      bus.start   = st;
      bus.abort   = ab;
      @(posedge clk);
      #1;
      bus.x_valid = 1'b0;
      bus.x_i     = 1'b0;
      bus.start   = 1'b0;
      bus.abort   = 1'b0;
      bus.cfg_we  = 1'b0;
   endtask

   task automatic set_cfg(input logic [15:0] p, input logic [4:0] l, input logic [15:0] to,
                          input logic c, input logic o);
      bus.cfg_we      = 1'b1;
      bus.cfg_pattern = p;
      bus.cfg_len     = l;
      bus.cfg_timeout = to;
      bus.cfg_cont    = c;
      bus.cfg_overlap = o;
   endtask

   task automatic send_bits(input logic [15:0] v, input int n, input bit gap);
      for (int i = n - 1; i >= 0; i--) begin
         drive(1'b1, v[i], 1'b0, 1'b0);
         if (gap) drive(1'b0, ~v[i], 1'b0, 1'b0);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      int s;
      checks = 0;
      errors = 0;
      cyc = 0;
      reset = 1'b1;
      bus.cfg_we = 1'b0; bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_timeout = '0;
      bus.cfg_cont = 1'b0; bus.cfg_overlap = 1'b0;
      bus.start = 1'b0; bus.abort = 1'b0; bus.x_valid = 1'b0; bus.x_i = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("reset_outputs", {bus.det_o, bus.busy_o, bus.done_o, bus.timeout_o, bus.cfg_err_o}, 0);
      chk("reset_match_cnt", bus.match_cnt_o, 0);
      chk("reset_state", bus.state_o, 0);
      reset = 1'b0;

      // start with no config written
      push(cyc + 1, 0, 0, 0, 1, 8'd0);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      chk("noconfig_busy", bus.busy_o, 0);
      chk("noconfig_state", bus.state_o, 0);

      // single-shot, config written together with start
      set_cfg(16'h0EDB, 5'd12, 16'd0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      chk("ss_busy", bus.busy_o, 1);
      push(cyc + 12, 1, 0, 0, 0, 8'd1);
      push(cyc + 13, 0, 1, 0, 0, 8'd1);
      send_bits(16'h0EDB, 12, 1'b0);
      idle(1);
      chk("ss_busy_after", bus.busy_o, 0);
      chk("ss_match_cnt", bus.match_cnt_o, 1);

      // overlapping continuous
      set_cfg(16'h0005, 5'd3, 16'd0, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      push(cyc + 3, 1, 0, 0, 0, 8'd1);
      push(cyc + 5, 1, 0, 0, 0, 8'd2);
      send_bits(16'h0015, 5, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      chk("ovl_match_cnt", bus.match_cnt_o, 2);
      chk("ovl_busy_after_abort", bus.busy_o, 0);

      // non-overlapping continuous
      set_cfg(16'h0005, 5'd3, 16'd0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      push(cyc + 3, 1, 0, 0, 0, 8'd1);
      send_bits(16'h0015, 5, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      chk("novl_match_cnt", bus.match_cnt_o, 1);

      // single-shot with x_valid gaps carrying inverted junk
      set_cfg(16'h0EDB, 5'd12, 16'd0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      push(cyc + 23, 1, 0, 0, 0, 8'd1);
      push(cyc + 24, 0, 1, 0, 0, 8'd1);
      send_bits(16'h0EDB, 12, 1'b1);
      idle(1);
      chk("gap_busy_after", bus.busy_o, 0);
      chk("gap_match_cnt", bus.match_cnt_o, 1);

      // timeout with no match
      set_cfg(16'h0005, 5'd3, 16'd20, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      s = cyc;
      push(s + 21, 0, 1, 1, 0, 8'd0);
      for (int i = 0; i < 25; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
      chk("to_busy_after", bus.busy_o, 0);
      chk("to_state_after", bus.state_o, 0);

      // match on the last cycle before timeout restarts the window
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      s = cyc;
      push(s + 20, 1, 0, 0, 0, 8'd1);
      push(s + 41, 0, 1, 1, 0, 8'd1);
      for (int i = 0; i < 17; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
      send_bits(16'h0005, 3, 1'b0);
      for (int i = 0; i < 25; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
      chk("to2_match_cnt", bus.match_cnt_o, 1);

      // abort coincident with a completing bit
      set_cfg(16'h0005, 5'd3, 16'd0, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      push(cyc + 3, 1, 0, 0, 0, 8'd1);
      send_bits(16'h0005, 3, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b1);
      chk("abort_match_cnt", bus.match_cnt_o, 1);
      chk("abort_state", bus.state_o, 0);
      chk("abort_det", bus.det_o, 0);

      // rejected lengths keep the old config
      set_cfg(16'h0007, 5'd0, 16'd0, 1'b0, 1'b0);
      push(cyc + 1, 0, 0, 0, 1, 8'd1);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      set_cfg(16'h0007, 5'd17, 16'd0, 1'b0, 1'b0);
      push(cyc + 1, 0, 0, 0, 1, 8'd1);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      // write while busy is refused and does not alter the pattern
      set_cfg(16'h0007, 5'd3, 16'd0, 1'b0, 1'b0);
      push(cyc + 1, 0, 0, 0, 1, 8'd0);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      push(cyc + 3, 1, 0, 0, 0, 8'd1);
      send_bits(16'h0005, 3, 1'b0);
      chk("busy_write_still_busy", bus.busy_o, 1);
      drive(1'b0, 1'b0, 1'b0, 1'b1);

      // asynchronous reset mid-HUNT
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      push(cyc + 3, 1, 0, 0, 0, 8'd1);
      send_bits(16'h0005, 3, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      chk("pre_reset_busy", bus.busy_o, 1);
      #2 reset = 1'b1;
      #1;
      chk("async_reset_busy", bus.busy_o, 0);
      chk("async_reset_match_cnt", bus.match_cnt_o, 0);
      chk("async_reset_state", bus.state_o, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      push(cyc + 1, 0, 0, 0, 1, 8'd0);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      idle(1);
      chk("post_reset_state", bus.state_o, 0);

      idle(3);
      chk("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
